// File: rtl/or_stream_packer.sv
// Packs the OR-gate result stream LSB-first into WIDTH-bit words.
// Frames close on in_last or a full word; output held until taken.
module or_stream_packer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bit,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       out_any
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             any_q, any_d;

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic [CW-1:0]    oc_q, oc_d;
  logic             oa_q, oa_d;

  logic [WIDTH-1:0] bit_m;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             close;
  logic             pop;

  assign in_ready = !ov_q || out_ready;
  assign take     = in_valid && in_ready;
  assign close    = take && (in_last || cnt_q == LAST);
  assign pop      = ov_q && out_ready;
  assign bit_m    = WIDTH'(in_bit) << cnt_q;
  assign word     = acc_q | bit_m;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    any_d = any_q;
    if (close) begin
      acc_d = '0;
      cnt_d = '0;
      any_d = 1'b0;
    end else if (take) begin
      acc_d = word;
      cnt_d = cnt_q + CW'(1);
      any_d = any_q | in_bit;
    end
  end

  // A close wins over a simultaneous pop: the register is refilled.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    oc_d = oc_q;
    oa_d = oa_q;
    if (close) begin
      ov_d = 1'b1;
      od_d = word;
      oc_d = cnt_q + CW'(1);
      oa_d = any_q | in_bit;
    end else if (pop) begin
      ov_d = 1'b0;
      od_d = '0;
      oc_d = '0;
      oa_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      any_q <= 1'b0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      oc_q  <= '0;
      oa_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      any_q <= any_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      oc_q  <= oc_d;
      oa_q  <= oa_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_count = oc_q;
  assign out_any   = oa_q;

endmodule

// File: tb/tb_or_stream_packer.sv
// Directed bench for or_stream_packer at WIDTH=8.
// Inputs change on the falling edge; outputs are checked there too.
module tb_or_stream_packer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_any;

  int errors;
  int checks;
  int bits_seen;

  or_stream_packer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_any   (out_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge; presents one beat across the next rising edge.
  task automatic beat(input logic b, input logic l);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", out_data); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", out_count); end
    checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL rst_any got=%b exp=0", out_any); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_full_word();
    logic [7:0] v;
    v = 8'b1000_1101;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) beat(v[i], 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", out_valid); end
    beat(v[7], 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h8D) begin errors++; $display("FAIL full_data got=%h exp=8d", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", out_count); end
    checks++; if (out_any !== 1'b1) begin errors++; $display("FAIL full_any got=%b exp=1", out_any); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_onecyc got=%b exp=0", out_valid); end
  endtask

  task automatic test_short_frame();
    out_ready = 1'b1;
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL short_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL short_data got=%h exp=02", out_data); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL short_count got=%0d exp=3", out_count); end
    checks++; if (out_any !== 1'b1) begin errors++; $display("FAIL short_any got=%b exp=1", out_any); end
    beat(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL single_data got=%h exp=00", out_data); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", out_count); end
    checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL single_any got=%b exp=0", out_any); end
    idle();
  endtask

  task automatic test_all_zero();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL zero_data got=%h exp=00", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL zero_count got=%0d exp=8", out_count); end
    checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL zero_any got=%b exp=0", out_any); end
    idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'h53;
    b = 8'hFD;
    bits_seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(a[i], 1'b0);
    bits_seen += int'(out_count);
    in_valid = 1'b1;
    in_bit   = b[0];
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h53 || out_count !== 4'd8) begin
        errors++; $display("FAIL bp_stable c%0d got=%b/%h/%0d exp=1/53/8", i, out_valid, out_data, out_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_taken got=%b exp=0", out_valid); end
    for (int i = 1; i < 8; i++) beat(b[i], 1'b0);
    checks++; if (out_data !== 8'hFD) begin errors++; $display("FAIL bp_next got=%h exp=fd", out_data); end
    bits_seen += int'(out_count);
    checks++; if (bits_seen !== 16) begin errors++; $display("FAIL bp_bits got=%0d exp=16", bits_seen); end
    idle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'b1, i == 3);
    checks++; if (out_data !== 8'h0F || out_count !== 4'd4) begin
      errors++; $display("FAIL b2b_w1 got=%h/%0d exp=0f/4", out_data, out_count);
    end
    beat(1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h01 || out_count !== 4'd1 || out_any !== 1'b1) begin
      errors++; $display("FAIL b2b_w2 got=%h/%0d/%b exp=01/1/1", out_data, out_count, out_any);
    end
    beat(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_any !== 1'b0) begin
      errors++; $display("FAIL b2b_w3 got=%b/%b exp=1/0", out_valid, out_any);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    beat(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 4'd0 || out_any !== 1'b0) begin
      errors++; $display("FAIL arst_out got=%b/%h/%0d/%b exp=0/00/0/0", out_valid, out_data, out_count, out_any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 4'd0) begin
      errors++; $display("FAIL mid_out got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_count);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_residue got=%b exp=0", out_valid); end
    beat(1'b1, 1'b0);
    checks++; if (out_data !== 8'hFF || out_count !== 4'd8 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_word got=%b/%h/%0d exp=1/ff/8", out_valid, out_data, out_count);
    end
    idle();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    bits_seen = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_short_frame();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
